// File: rtl/apsk_symbol_mapper.sv
// apsk_symbol_mapper: LSB-first bit unpacker feeding a loadable {I,Q} constellation LUT.
// Each input word is split into k-bit symbols. k is latched at frame start.
// At frame end, any residual bits are zero-padded into one last symbol.
// The output is registered and has a 2-entry skid buffer, so it tolerates backpressure.
// Optional feature: define APSK_SYMBOL_MAPPER_COUNT_EN to add the symbol_count[15:0] output.
module apsk_symbol_mapper #(
  parameter int DATA_IN_TDATA_WIDTH   = 32,
  parameter int MAX_BITS_PER_SYMBOL   = 8,
  parameter int SAMPLE_WIDTH          = 16,
  parameter int BITS_PER_SYMBOL_WIDTH = 4
) (
  input  logic                             aclk,
  input  logic                             reset,
  output logic                             data_in_tready,
  input  logic [DATA_IN_TDATA_WIDTH-1:0]   data_in_tdata,
  input  logic                             data_in_tlast,
  input  logic                             data_in_tvalid,
  input  logic                             data_out_tready,
  output logic [2*SAMPLE_WIDTH-1:0]        data_out_tdata,
  output logic                             data_out_tlast,
  output logic                             data_out_tvalid,
  output logic                             lut_data_load_tready,
  input  logic [2*SAMPLE_WIDTH-1:0]        lut_data_load_tdata,
  input  logic                             lut_data_load_tlast,
  input  logic                             lut_data_load_tvalid,
  input  logic [BITS_PER_SYMBOL_WIDTH-1:0] bits_per_symbol,
`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
  output logic [15:0]                      symbol_count,
`endif
  output logic                             config_error
);
  localparam int SR_W  = DATA_IN_TDATA_WIDTH + MAX_BITS_PER_SYMBOL;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam int OW    = 2 * SAMPLE_WIDTH;
  localparam int DEPTH = 2 ** MAX_BITS_PER_SYMBOL;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                           state_q, state_d;
  logic [BITS_PER_SYMBOL_WIDTH-1:0] k_q, k_d;
  logic [SR_W-1:0]                  sr_q, sr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             v1_q, v1_d, last1_q, last1_d;
  logic [MAX_BITS_PER_SYMBOL-1:0]   addr1_q, addr1_d;
  logic                             v2_q, last2_q;
  logic [OW-1:0]                    rd_data_q;
  logic [OW-1:0]                    out_data_q, out_data_d;
  logic                             out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic [OW:0]                      skid_q [2];
  logic [OW:0]                      skid_d [2];
  logic [1:0]                       skid_cnt_q, skid_cnt_d;
  logic [MAX_BITS_PER_SYMBOL-1:0]   waddr_q, waddr_d;
  logic [OW-1:0]                    lut_mem [DEPTH];

  logic                             k_legal, in_hs, lut_wr, pop, extract, ext_last, ext_ok;
  logic [CNT_W-1:0]                 k_ext;
  logic [MAX_BITS_PER_SYMBOL-1:0]   sym_mask;
  logic [2:0]                       inflight, n_ent;
  logic [OW:0]                      ent [4];

  assign k_legal  = (bits_per_symbol != '0) && (int'(bits_per_symbol) <= MAX_BITS_PER_SYMBOL);
  assign in_hs    = data_in_tvalid && data_in_tready;
  assign lut_wr   = lut_data_load_tvalid && lut_data_load_tready;
  assign pop      = out_valid_q && data_out_tready;
  assign k_ext    = CNT_W'(k_q);
  assign sym_mask = ~({MAX_BITS_PER_SYMBOL{1'b1}} << k_q);

  assign data_out_tdata  = out_data_q;
  assign data_out_tlast  = out_last_q;
  assign data_out_tvalid = out_valid_q;

  // FSM state register
  always_ff @(posedge aclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: the entry word may already be the last word of the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = data_in_tlast ? FLUSH : RUN;
      RUN:     if (in_hs && data_in_tlast) state_d = FLUSH;
      FLUSH:   if (pop && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: input/LUT readies; a pending LUT load blocks frame start
  always_comb begin
    data_in_tready       = 1'b0;
    lut_data_load_tready = 1'b0;
    config_error         = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          lut_data_load_tready = 1'b1;
          data_in_tready       = k_legal && !lut_data_load_tvalid;
          config_error         = data_in_tvalid && !k_legal;
        end
        RUN:     data_in_tready = (count_q < k_ext);
        default: ;
      endcase
    end
  end

  // Unpacker: append words above the residual bits, extract k LSBs while credit allows
  always_comb begin
    // Items either in the pipeline or buffered must fit in the output register plus the 2-entry skid
    inflight = {2'b0, v1_q} + {2'b0, v2_q} + {2'b0, out_valid_q} + {1'b0, skid_cnt_q} - {2'b0, pop};
    ext_ok   = (inflight <= 3'd2);
    extract  = ext_ok && (((state_q == RUN) && (count_q >= k_ext)) ||
                          ((state_q == FLUSH) && (count_q != '0)));
    ext_last = (state_q == FLUSH) && (count_q <= k_ext);
    k_d      = k_q;
    sr_d     = sr_q;
    count_d  = count_q;
    if (state_q == IDLE && in_hs) k_d = bits_per_symbol;
    if (in_hs) begin
      sr_d    = sr_q | (SR_W'(data_in_tdata) << count_q);
      count_d = count_q + CNT_W'(DATA_IN_TDATA_WIDTH);
    end else if (extract) begin
      // Bits above count are always zero, so a short final symbol is zero-padded automatically
      sr_d    = sr_q >> k_q;
      count_d = (count_q > k_ext) ? (count_q - k_ext) : '0;
    end
    v1_d    = extract;
    last1_d = extract && ext_last;
    addr1_d = extract ? (sr_q[MAX_BITS_PER_SYMBOL-1:0] & sym_mask) : addr1_q;
  end

  // Output queue: the register holds the head, skid holds up to two more, LUT data arrives at the tail
  always_comb begin
    for (int i = 0; i < 4; i++) ent[i] = '0;
    n_ent = '0;
    if (out_valid_q && !pop) begin
      ent[n_ent[1:0]] = {out_last_q, out_data_q};
      n_ent = n_ent + 3'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (i < int'(skid_cnt_q)) begin
        ent[n_ent[1:0]] = skid_q[i];
        n_ent = n_ent + 3'd1;
      end
    end
    if (v2_q) begin
      ent[n_ent[1:0]] = {last2_q, rd_data_q};
      n_ent = n_ent + 3'd1;
    end
    out_valid_d = (n_ent != '0);
    out_last_d  = ent[0][OW];
    out_data_d  = ent[0][OW-1:0];
    skid_d[0]   = ent[1];
    skid_d[1]   = ent[2];
    skid_cnt_d  = (n_ent > 3'd1) ? 2'(n_ent - 3'd1) : 2'd0;
  end

  // LUT write address: increments per write, wraps naturally, returns to 0 on tlast
  always_comb begin
    waddr_d = waddr_q;
    if (lut_wr) waddr_d = lut_data_load_tlast ? '0 : waddr_q + 1'b1;
  end

  // Datapath and pipeline registers
  always_ff @(posedge aclk) begin
    if (reset) begin
      k_q         <= '0;
      sr_q        <= '0;
      count_q     <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      addr1_q     <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      skid_cnt_q  <= '0;
      waddr_q     <= '0;
    end else begin
      k_q         <= k_d;
      sr_q        <= sr_d;
      count_q     <= count_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      addr1_q     <= addr1_d;
      v2_q        <= v1_q;
      last2_q     <= last1_q;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      skid_cnt_q  <= skid_cnt_d;
      waddr_q     <= waddr_d;
    end
  end

  // Skid entries
  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge aclk) begin
      if (reset) skid_q[gi] <= '0;
      else       skid_q[gi] <= skid_d[gi];
    end
  end

  // Constellation RAM with registered read; contents survive reset
  always_ff @(posedge aclk) begin
    if (lut_wr) lut_mem[waddr_q] <= lut_data_load_tdata;
    rd_data_q <= lut_mem[addr1_q];
  end

`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
  logic [15:0] sym_cnt_q, sym_cnt_d;

  // Per-frame output symbol counter, saturating, held after the frame
  always_comb begin
    sym_cnt_d = sym_cnt_q;
    if (state_q == IDLE && in_hs)          sym_cnt_d = '0;
    else if (pop && sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge aclk) begin
    if (reset) sym_cnt_q <= '0;
    else       sym_cnt_q <= sym_cnt_d;
  end

  assign symbol_count = sym_cnt_q;
`endif
endmodule

// File: tb/tb_apsk_symbol_mapper.sv
// Directed bench for apsk_symbol_mapper: LUT load, k=2/3/4/6/8 frames, backpressure,
// config error, mid-frame k change, and mid-frame reset.
module tb_apsk_symbol_mapper;
  logic        aclk = 1'b0;
  logic        reset;
  logic        data_in_tready;
  logic [31:0] data_in_tdata;
  logic        data_in_tlast;
  logic        data_in_tvalid;
  logic        data_out_tready;
  logic [31:0] data_out_tdata;
  logic        data_out_tlast;
  logic        data_out_tvalid;
  logic        lut_data_load_tready;
  logic [31:0] lut_data_load_tdata;
  logic        lut_data_load_tlast;
  logic        lut_data_load_tvalid;
  logic [3:0]  bits_per_symbol;
  logic        config_error;
`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
  logic [15:0] symbol_count;
`endif

  apsk_symbol_mapper dut (
    .aclk                 (aclk),
    .reset                (reset),
    .data_in_tready       (data_in_tready),
    .data_in_tdata        (data_in_tdata),
    .data_in_tlast        (data_in_tlast),
    .data_in_tvalid       (data_in_tvalid),
    .data_out_tready      (data_out_tready),
    .data_out_tdata       (data_out_tdata),
    .data_out_tlast       (data_out_tlast),
    .data_out_tvalid      (data_out_tvalid),
    .lut_data_load_tready (lut_data_load_tready),
    .lut_data_load_tdata  (lut_data_load_tdata),
    .lut_data_load_tlast  (lut_data_load_tlast),
    .lut_data_load_tvalid (lut_data_load_tvalid),
    .bits_per_symbol      (bits_per_symbol),
`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
    .symbol_count         (symbol_count),
`endif
    .config_error         (config_error)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] lut_mdl [256];
  int          wa_mdl = 0;
  logic [32:0] exp_q [$];
  int          rx_cnt = 0;
  logic        last_seen = 1'b0;
  logic        rdy_toggle = 1'b0;
  logic        stall_prev = 1'b0;
  logic [32:0] stall_val;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: constant 1, or toggled every cycle
  always @(posedge aclk) begin
    #1;
    if (rdy_toggle) data_out_tready = ~data_out_tready;
    else            data_out_tready = 1'b1;
  end

  // Output monitor: scoreboard compare on handshake, hold check while stalled
  always @(negedge aclk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("stall_valid", data_out_tvalid, 1'b1);
        check_val("stall_hold", {data_out_tlast, data_out_tdata}, stall_val);
      end
      if (data_out_tvalid && data_out_tready) begin
        check_val("sym_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_val("sym", {data_out_tlast, data_out_tdata}, exp_q.pop_front());
        $display("[TB] sym %0d tdata=0x%08h tlast=%0d", rx_cnt, data_out_tdata, data_out_tlast);
        rx_cnt++;
        if (data_out_tlast) last_seen = 1'b1;
      end
      stall_prev = data_out_tvalid && !data_out_tready;
      stall_val  = {data_out_tlast, data_out_tdata};
    end
  end

  task automatic push_exp(input int addr, input logic last);
    exp_q.push_back({last, lut_mdl[addr]});
  endtask

  task automatic start_frame();
    rx_cnt = 0;
    last_seen = 1'b0;
  endtask

  task automatic lut_write(input logic [31:0] d, input logic last, input logic chk_prio);
    logic done = 1'b0;
    lut_data_load_tdata  = d;
    lut_data_load_tlast  = last;
    lut_data_load_tvalid = 1'b1;
    for (int g = 0; g < 50 && !done; g++) begin
      @(negedge aclk);
      if (lut_data_load_tready) begin
        if (chk_prio) check_val("prio_in_rdy", data_in_tready, 1'b0);
        done = 1'b1;
      end
    end
    if (!done) check_val("lut_hs", done, 1'b1);
    @(posedge aclk); #1;
    lut_data_load_tvalid = 1'b0;
    lut_mdl[wa_mdl] = d;
    wa_mdl = last ? 0 : (wa_mdl + 1) % 256;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    logic done = 1'b0;
    data_in_tdata  = w;
    data_in_tlast  = last;
    data_in_tvalid = 1'b1;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge aclk);
      if (data_in_tready) done = 1'b1;
    end
    if (!done) check_val("in_hs", done, 1'b1);
    @(posedge aclk); #1;
    data_in_tvalid = 1'b0;
    $display("[TB] word 0x%08h tlast=%0d k=%0d", w, last, bits_per_symbol);
  endtask

  task automatic wait_done(input int n_exp);
    logic done = 1'b0;
    for (int g = 0; g < 3000 && !done; g++) begin
      @(posedge aclk); #1;
      if (exp_q.size() == 0 && last_seen) done = 1'b1;
    end
    check_val("frame_done", done, 1'b1);
    check_val("frame_nsym", rx_cnt, n_exp);
`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
    check_val("symbol_count", symbol_count, n_exp);
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    data_in_tdata = '0; data_in_tlast = 1'b0; data_in_tvalid = 1'b0;
    data_out_tready = 1'b1;
    lut_data_load_tdata = '0; lut_data_load_tlast = 1'b0; lut_data_load_tvalid = 1'b0;
    bits_per_symbol = 4'd2;
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_out_valid", data_out_tvalid, 1'b0);
    check_val("rst_out_data", data_out_tdata, 32'h0);
    check_val("rst_out_last", data_out_tlast, 1'b0);
    check_val("rst_cfg_err", config_error, 1'b0);
    check_val("rst_in_rdy", data_in_tready, 1'b0);
    check_val("rst_lut_rdy", lut_data_load_tready, 1'b0);
    reset = 1'b0;
    #1;
    check_val("idle_lut_rdy", lut_data_load_tready, 1'b1);

    // Fill every LUT entry; address wraps from 255 to 0
    for (int a = 0; a < 256; a++)
      lut_write({16'(a) ^ 16'hA500, 16'(a * 3 + 7)}, 1'b0, 1'b0);

    // Test 1: 4-entry load with tlast, read back with k=2
    for (int i = 0; i < 4; i++)
      lut_write({16'(i * 257), 16'(i * 257)}, i == 3, 1'b0);
    bits_per_symbol = 4'd2;
    start_frame();
    for (int i = 0; i < 16; i++) push_exp((i < 4) ? i : 0, i == 15);
    send_word(32'h0000_00E4, 1'b1);
    wait_done(16);

    // Load has priority over a waiting frame; tlast returns the address to 0
    data_in_tdata = 32'h0; data_in_tlast = 1'b0; data_in_tvalid = 1'b1;
    lut_write(32'h1111_2222, 1'b0, 1'b1);
    data_in_tvalid = 1'b0;
    lut_write(32'h3333_4444, 1'b1, 1'b0);

    // Test 2: k=3, all ones, 2-bit padded tail; latency of first output
    bits_per_symbol = 4'd3;
    start_frame();
    for (int i = 0; i < 10; i++) push_exp(7, 1'b0);
    push_exp(3, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b1);
    check_val("lat_e0", data_out_tvalid, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    check_val("lat_e2", data_out_tvalid, 1'b0);
    @(posedge aclk); #1;
    check_val("lat_e3", data_out_tvalid, 1'b1);
    wait_done(11);

    // Test 3: k=8, 4 words, ready toggling each cycle
    bits_per_symbol = 4'd8;
    rdy_toggle = 1'b1;
    start_frame();
    for (int i = 0; i < 16; i++) push_exp(i, i == 15);
    send_word(32'h0302_0100, 1'b0);
    send_word(32'h0706_0504, 1'b0);
    send_word(32'h0B0A_0908, 1'b0);
    send_word(32'h0F0E_0D0C, 1'b1);
    wait_done(16);
    rdy_toggle = 1'b0;

    // Test 4: illegal k=0 holds off the frame, then k=4
    bits_per_symbol = 4'd0;
    data_in_tdata = 32'h7654_3210; data_in_tlast = 1'b1; data_in_tvalid = 1'b1;
    @(negedge aclk);
    check_val("cfg_err_k0", config_error, 1'b1);
    check_val("cfg_in_rdy_k0", data_in_tready, 1'b0);
    @(posedge aclk); #1;
    bits_per_symbol = 4'd4;
    #1;
    check_val("cfg_err_k4", config_error, 1'b0);
    check_val("cfg_in_rdy_k4", data_in_tready, 1'b1);
    start_frame();
    for (int i = 0; i < 8; i++) push_exp(i, i == 7);
    send_word(32'h7654_3210, 1'b1);
    wait_done(8);

    // Test 5: k changed from 2 to 6 mid-frame, then a k=6 frame
    bits_per_symbol = 4'd2;
    start_frame();
    for (int i = 0; i < 16; i++) push_exp((i < 4) ? i : 0, 1'b0);
    for (int i = 0; i < 16; i++) push_exp((i < 4) ? 3 - i : 0, i == 15);
    send_word(32'h0000_00E4, 1'b0);
    bits_per_symbol = 4'd6;
    send_word(32'h0000_001B, 1'b1);
    wait_done(32);
    start_frame();
    push_exp(5, 1'b0); push_exp(9, 1'b0); push_exp(63, 1'b0);
    push_exp(1, 1'b0); push_exp(2, 1'b0); push_exp(3, 1'b1);
    send_word(32'hC207_F245, 1'b1);
    wait_done(6);

    // Test 6: reset after 5 symbols of an open frame
    bits_per_symbol = 4'd2;
    start_frame();
    for (int i = 0; i < 16; i++) push_exp((i < 4) ? i : 0, 1'b0);
    send_word(32'h0000_00E4, 1'b0);
    begin
      logic got5 = 1'b0;
      for (int g = 0; g < 200 && !got5; g++) begin
        @(posedge aclk); #1;
        if (rx_cnt >= 5) got5 = 1'b1;
      end
      check_val("rst_wait5", got5, 1'b1);
    end
    reset = 1'b1;
    @(posedge aclk); #1;
    check_val("mid_rst_valid", data_out_tvalid, 1'b0);
    check_val("mid_rst_data", data_out_tdata, 32'h0);
    check_val("mid_rst_last", data_out_tlast, 1'b0);
    check_val("mid_rst_in_rdy", data_in_tready, 1'b0);
`ifdef APSK_SYMBOL_MAPPER_COUNT_EN
    check_val("mid_rst_count", symbol_count, 16'h0);
`endif
    exp_q.delete();
    reset = 1'b0;
    #1;
    check_val("post_rst_lut_rdy", lut_data_load_tready, 1'b1);

    // LUT contents survive reset
    bits_per_symbol = 4'd8;
    start_frame();
    for (int i = 0; i < 4; i++) push_exp(i, 1'b0);
    for (int i = 252; i < 256; i++) push_exp(i, i == 255);
    send_word(32'h0302_0100, 1'b0);
    send_word(32'hFFFE_FDFC, 1'b1);
    wait_done(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
